// File: rtl/framed_word_unpacker_if.sv
// Stream bundle between the framed link, the unpacker and the payload consumer.
// The slave modport is the unpacker's view; the master modport is the environment's view.
interface framed_word_unpacker_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [15:0] out_free;

    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_data, out_free
    );

    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_data, out_free
    );
endinterface

// File: rtl/framed_word_unpacker.sv
// Checks 64-bit framed words against a masked tag pattern. While locked, it forwards
// matching payloads through a one-deep output register and keeps saturating match/miss counts.
module framed_word_unpacker #(
    parameter logic [31:0] EXP_TAG   = 32'h0BD0_0000,
    parameter logic [31:0] CARE_MASK = 32'hFFF0_000F,
    parameter int          LOCK_CNT  = 3,
    parameter int          LOSS_CNT  = 2,
    parameter int          CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    framed_word_unpacker_if.slave   bus,
    output logic                    locked,
    output logic                    tag_err,
    output logic [CNT_W-1:0]        good_cnt,
    output logic [CNT_W-1:0]        bad_cnt
);

    localparam int RUN_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
    localparam int RUN_W   = (RUN_MAX < 2) ? 1 : $clog2(RUN_MAX + 1);
    localparam logic [RUN_W-1:0] LOCK_LAST = RUN_W'(LOCK_CNT - 1);
    localparam logic [RUN_W-1:0] LOSS_LAST = RUN_W'(LOSS_CNT - 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [RUN_W-1:0]   match_run_q, match_run_d;
    logic [RUN_W-1:0]   miss_run_q, miss_run_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_data_q, out_data_d;
    logic [15:0]        out_free_q, out_free_d;
    logic               tag_err_q, tag_err_d;
    logic [CNT_W-1:0]   good_q, good_d;
    logic [CNT_W-1:0]   bad_q, bad_d;

    logic               in_ready;
    logic               accept;
    logic               match;
    logic               load;

    // Flow-through register: space exists when empty or being drained this cycle.
    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign match    = ((bus.in_word[63:32] ^ EXP_TAG) & CARE_MASK) == 32'h0;
    assign load     = accept && match && (state_q == LOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            match_run_q <= '0;
            miss_run_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_free_q  <= '0;
            tag_err_q   <= 1'b0;
            good_q      <= '0;
            bad_q       <= '0;
        end else begin
            state_q     <= state_d;
            match_run_q <= match_run_d;
            miss_run_q  <= miss_run_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_free_q  <= out_free_d;
            tag_err_q   <= tag_err_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        match_run_d = match_run_q;
        miss_run_d  = miss_run_q;
        if (accept) begin
            case (state_q)
                HUNT: begin
                    if (!match) begin
                        match_run_d = '0;
                    end else if (match_run_q == LOCK_LAST) begin
                        state_d     = LOCKED;
                        match_run_d = '0;
                        miss_run_d  = '0;
                    end else begin
                        match_run_d = match_run_q + 1'b1;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        miss_run_d = '0;
                    end else if (miss_run_q == LOSS_LAST) begin
                        state_d     = HUNT;
                        match_run_d = '0;
                        miss_run_d  = '0;
                    end else begin
                        miss_run_d = miss_run_q + 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_free_d  = out_free_q;
        tag_err_d   = accept && !match;
        good_d      = good_q;
        bad_d       = bad_q;

        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in_word[31:0];
            out_free_d  = bus.in_word[51:36];
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        // Counters saturate at all-ones instead of wrapping.
        if (accept && match && (good_q != {CNT_W{1'b1}})) begin
            good_d = good_q + 1'b1;
        end
        if (accept && !match && (bad_q != {CNT_W{1'b1}})) begin
            bad_d = bad_q + 1'b1;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_free  = out_free_q;
    assign locked        = (state_q == LOCKED);
    assign tag_err       = tag_err_q;
    assign good_cnt      = good_q;
    assign bad_cnt       = bad_q;

endmodule

// File: tb/tb_framed_word_unpacker.sv
// Directed bench: one default-sized unpacker for lock/forward/loss/backpressure,
// and a CNT_W=4 instance to reach counter saturation quickly.
module tb_framed_word_unpacker;

    logic        clk;
    logic        rst;
    logic        locked, tag_err;
    logic [15:0] good_cnt, bad_cnt;
    logic        s_locked, s_tag_err;
    logic [3:0]  s_good, s_bad;
    int          total;
    int          bad;

    framed_word_unpacker_if bus ();
    framed_word_unpacker_if sbus ();

    framed_word_unpacker dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .locked   (locked),
        .tag_err  (tag_err),
        .good_cnt (good_cnt),
        .bad_cnt  (bad_cnt)
    );

    framed_word_unpacker #(.CNT_W(4)) dut_sat (
        .clk      (clk),
        .rst      (rst),
        .bus      (sbus),
        .locked   (s_locked),
        .tag_err  (s_tag_err),
        .good_cnt (s_good),
        .bad_cnt  (s_bad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_word = 64'h0;
        bus.out_ready = 1'b1;
        sbus.in_valid = 1'b0;
        sbus.in_word = 64'h0;
        sbus.out_ready = 1'b1;
        step();
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_valid got=%0h want=0", bus.out_valid); end
        total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL rst_locked got=%0h want=0", locked); end
        total++; if (tag_err !== 1'b0) begin bad++; $display("[TB] FAIL rst_tag_err got=%0h want=0", tag_err); end
        total++; if (good_cnt !== 16'd0) begin bad++; $display("[TB] FAIL rst_good got=%0d want=0", good_cnt); end
        total++; if (bad_cnt !== 16'd0) begin bad++; $display("[TB] FAIL rst_bad got=%0d want=0", bad_cnt); end
        total++; if (bus.out_data !== 32'h0) begin bad++; $display("[TB] FAIL rst_out_data got=%h want=0", bus.out_data); end
        total++; if (bus.out_free !== 16'h0) begin bad++; $display("[TB] FAIL rst_out_free got=%h want=0", bus.out_free); end
        rst = 1'b0;
    endtask

    task automatic test_lock;
        bus.in_valid = 1'b1;
        bus.in_word = 64'h0BD5_A5A0_1111_0000;
        step();
        total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL lock_w1_locked got=%0h want=0", locked); end
        bus.in_word = 64'h0BDF_FFF0_2222_0000;
        step();
        total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL lock_w2_locked got=%0h want=0", locked); end
        bus.in_word = 64'h0BD0_0000_3333_0000;
        step();
        bus.in_valid = 1'b0;
        total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL lock_w3_locked got=%0h want=1", locked); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL lock_no_fwd got=%0h want=0", bus.out_valid); end
        total++; if (good_cnt !== 16'd3) begin bad++; $display("[TB] FAIL lock_good got=%0d want=3", good_cnt); end
        total++; if (tag_err !== 1'b0) begin bad++; $display("[TB] FAIL lock_tag_err got=%0h want=0", tag_err); end
    endtask

    task automatic test_forward;
        bus.in_valid = 1'b1;
        bus.in_word = 64'h0BD1_2340_DEAD_BEEF;
        step();
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL fwd_valid got=%0h want=1", bus.out_valid); end
        total++; if (bus.out_data !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL fwd_data got=%h want=deadbeef", bus.out_data); end
        total++; if (bus.out_free !== 16'h1234) begin bad++; $display("[TB] FAIL fwd_free got=%h want=1234", bus.out_free); end
        total++; if (good_cnt !== 16'd4) begin bad++; $display("[TB] FAIL fwd_good got=%0d want=4", good_cnt); end
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL fwd_drain got=%0h want=0", bus.out_valid); end
    endtask

    task automatic test_single_miss;
        bus.in_valid = 1'b1;
        bus.in_word = 64'h0BD0_0001_0000_0001;
        step();
        total++; if (tag_err !== 1'b1) begin bad++; $display("[TB] FAIL miss_tag_err got=%0h want=1", tag_err); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL miss_no_fwd got=%0h want=0", bus.out_valid); end
        total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL miss_locked got=%0h want=1", locked); end
        total++; if (bad_cnt !== 16'd1) begin bad++; $display("[TB] FAIL miss_bad got=%0d want=1", bad_cnt); end
        bus.in_word = 64'h0BD0_0000_0000_0002;
        step();
        bus.in_valid = 1'b0;
        total++; if (tag_err !== 1'b0) begin bad++; $display("[TB] FAIL miss_tag_err_clr got=%0h want=0", tag_err); end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL miss_fwd_valid got=%0h want=1", bus.out_valid); end
        total++; if (bus.out_data !== 32'h2) begin bad++; $display("[TB] FAIL miss_fwd_data got=%h want=2", bus.out_data); end
        total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL miss_still_locked got=%0h want=1", locked); end
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL miss_drain got=%0h want=0", bus.out_valid); end
        total++; if (bad_cnt !== 16'd1) begin bad++; $display("[TB] FAIL miss_bad_hold got=%0d want=1", bad_cnt); end
    endtask

    task automatic test_loss;
        bus.in_valid = 1'b1;
        bus.in_word = 64'h1BD0_0000_0000_AAAA;
        step();
        total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL loss_first_locked got=%0h want=1", locked); end
        total++; if (tag_err !== 1'b1) begin bad++; $display("[TB] FAIL loss_first_tag_err got=%0h want=1", tag_err); end
        bus.in_word = 64'h1BD0_0000_0000_AAAB;
        step();
        total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL loss_second_locked got=%0h want=0", locked); end
        total++; if (bad_cnt !== 16'd3) begin bad++; $display("[TB] FAIL loss_bad got=%0d want=3", bad_cnt); end
        bus.in_word = 64'h0BD0_0000_0000_BBBB;
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL loss_hunt_no_fwd got=%0h want=0", bus.out_valid); end
        total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL loss_hunt_locked got=%0h want=0", locked); end
        total++; if (good_cnt !== 16'd6) begin bad++; $display("[TB] FAIL loss_good got=%0d want=6", good_cnt); end
        step();
        total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL relock_run2_locked got=%0h want=0", locked); end
        step();
        bus.in_valid = 1'b0;
        total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL relock_locked got=%0h want=1", locked); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL relock_no_fwd got=%0h want=0", bus.out_valid); end
        total++; if (good_cnt !== 16'd8) begin bad++; $display("[TB] FAIL relock_good got=%0d want=8", good_cnt); end
    endtask

    task automatic test_backpressure;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_word = 64'h0BD0_5550_0000_00A1;
        step();
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_load_valid got=%0h want=1", bus.out_valid); end
        total++; if (bus.out_data !== 32'hA1) begin bad++; $display("[TB] FAIL bp_load_data got=%h want=a1", bus.out_data); end
        bus.in_word = 64'h0BD0_0000_0000_00A2;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready got=%0h want=0", bus.in_ready); end
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (bus.out_data !== 32'hA1) begin bad++; $display("[TB] FAIL bp_hold_data got=%h want=a1", bus.out_data); end
            total++; if (bus.out_free !== 16'h0555) begin bad++; $display("[TB] FAIL bp_hold_free got=%h want=0555", bus.out_free); end
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_hold_valid got=%0h want=1", bus.out_valid); end
        end
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_ready got=%0h want=1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_swap_valid got=%0h want=1", bus.out_valid); end
        total++; if (bus.out_data !== 32'hA2) begin bad++; $display("[TB] FAIL bp_swap_data got=%h want=a2", bus.out_data); end
        total++; if (good_cnt !== 16'd10) begin bad++; $display("[TB] FAIL bp_good got=%0d want=10", good_cnt); end
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drain got=%0h want=0", bus.out_valid); end
    endtask

    task automatic test_saturation_and_reset;
        logic [3:0] exp_good;
        sbus.out_ready = 1'b1;
        sbus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sbus.in_word = {32'h0BD0_0000, 32'(i)};
            step();
            exp_good = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
            total++; if (s_good !== exp_good) begin bad++; $display("[TB] FAIL sat_good_%0d got=%0d want=%0d", i, s_good, exp_good); end
        end
        total++; if (s_locked !== 1'b1) begin bad++; $display("[TB] FAIL sat_locked got=%0h want=1", s_locked); end
        total++; if (sbus.out_data !== 32'd19) begin bad++; $display("[TB] FAIL sat_last_data got=%0d want=19", sbus.out_data); end
        total++; if (s_bad !== 4'd0) begin bad++; $display("[TB] FAIL sat_bad got=%0d want=0", s_bad); end
        sbus.in_valid = 1'b0;
        sbus.out_ready = 1'b0;
        step();
        total++; if (sbus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL sat_held_valid got=%0h want=1", sbus.out_valid); end
        rst = 1'b1;
        sbus.in_valid = 1'b1;
        sbus.in_word = 64'h0BD0_0000_0000_0077;
        step();
        total++; if (sbus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst2_out_valid got=%0h want=0", sbus.out_valid); end
        total++; if (s_locked !== 1'b0) begin bad++; $display("[TB] FAIL rst2_locked got=%0h want=0", s_locked); end
        total++; if (s_good !== 4'd0) begin bad++; $display("[TB] FAIL rst2_good got=%0d want=0", s_good); end
        total++; if (s_bad !== 4'd0) begin bad++; $display("[TB] FAIL rst2_bad got=%0d want=0", s_bad); end
        total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL rst2_main_locked got=%0h want=0", locked); end
        total++; if (good_cnt !== 16'd0) begin bad++; $display("[TB] FAIL rst2_main_good got=%0d want=0", good_cnt); end
        rst = 1'b0;
        sbus.in_valid = 1'b0;
        step();
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_lock();
        test_forward();
        test_single_miss();
        test_loss();
        test_backpressure();
        test_saturation_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
